// File: rtl/fns_encoder_seq.sv
// Sequential binary-to-Fibonacci (Zeckendorf) encoder that emits one code digit per clock, MSB first, using greedy subtraction.
// Optional build macro: FNS_ENC_SELFCHECK_EN adds o_chk_err and a weighted-sum consistency checker.
module fns_encoder_seq #(
    parameter int N_BITS = 9,
    parameter int CODE_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    input  logic [N_BITS-1:0] i_in_data,
    output logic              o_out_valid,
    input  logic              i_out_ready,
    output logic [CODE_W-1:0] o_code_out,
    output logic              o_err_flag,
    output logic [1:0]        o_dbg_state
`ifdef FNS_ENC_SELFCHECK_EN
    ,output logic             o_chk_err
`endif
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    // The source may not make valid wait for ready. Data is sampled only on that edge.
    localparam int RES_W = N_BITS + 1;
    localparam int IDX_W = (CODE_W > 1) ? $clog2(CODE_W) : 1;

    typedef logic [CODE_W-1:0][31:0] wtab_t;

    function automatic wtab_t gen_weights();
        wtab_t t;
        t = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (i == 0)      t[i] = 32'd1;
            else if (i == 1) t[i] = 32'd2;
            else             t[i] = t[i-1] + t[i-2];
        end
        return t;
    endfunction

    localparam wtab_t       W    = gen_weights();
    localparam logic [31:0] MAXV = W[CODE_W-1] + W[CODE_W-2] - 32'd1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ENC  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_out_valid;
    logic [CODE_W-1:0] r_code;
    logic              r_err;
    logic [RES_W-1:0]  r_residue;
    logic [IDX_W-1:0]  r_idx;

    logic [31:0]       w_res32;
    logic [31:0]       w_wt;
    logic [31:0]       w_in32;
    logic              w_take;
    logic [CODE_W-1:0] w_code_next;
    logic [RES_W-1:0]  w_res_next;

    // One greedy step: the digit at r_idx is set whenever its weight still fits in the residue.
    always_comb begin
        w_res32     = 32'(r_residue);
        w_wt        = W[r_idx];
        w_in32      = 32'(i_in_data);
        w_take      = (w_res32 >= w_wt);
        w_code_next = r_code;
        w_res_next  = r_residue;
        if (w_take) begin
            w_code_next = r_code | (CODE_W'(1) << r_idx);
            w_res_next  = RES_W'(w_res32 - w_wt);
        end
    end

`ifdef FNS_ENC_SELFCHECK_EN
    logic [N_BITS-1:0] r_orig;
    logic              r_chk;
    logic [31:0]       w_sum;
    logic              w_chk_fail;

    function automatic logic [31:0] weighted_sum(input logic [CODE_W-1:0] c);
        logic [31:0] s;
        s = '0;
        for (int i = 0; i < CODE_W; i++) begin
            if (c[i]) s = s + W[i];
        end
        return s;
    endfunction

    // Evaluated on the final greedy step, i.e. on the codeword that DONE will present.
    always_comb begin
        w_sum      = weighted_sum(w_code_next);
        w_chk_fail = (w_res_next != '0)
                   || ((w_code_next & (w_code_next >> 1)) != '0)
                   || (w_sum != 32'(r_orig));
    end

    assign o_chk_err = r_chk;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_code      <= '0;
            r_err       <= 1'b0;
            r_residue   <= '0;
            r_idx       <= '0;
`ifdef FNS_ENC_SELFCHECK_EN
            r_orig      <= '0;
            r_chk       <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (i_in_valid && r_in_ready) begin
                        r_in_ready <= 1'b0;
                        r_code     <= '0;
                        if (w_in32 > MAXV) begin
                            r_err       <= 1'b1;
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
`ifdef FNS_ENC_SELFCHECK_EN
                            r_chk       <= 1'b0;
`endif
                        end else begin
                            r_err     <= 1'b0;
                            r_residue <= {1'b0, i_in_data};
                            r_idx     <= IDX_W'(CODE_W - 1);
                            r_state   <= S_ENC;
`ifdef FNS_ENC_SELFCHECK_EN
                            r_orig    <= i_in_data;
`endif
                        end
                    end
                end
                S_ENC: begin
                    r_code    <= w_code_next;
                    r_residue <= w_res_next;
                    if (r_idx == '0) begin
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
`ifdef FNS_ENC_SELFCHECK_EN
                        r_chk       <= w_chk_fail;
`endif
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                S_DONE: begin
                    if (i_out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
`ifdef FNS_ENC_SELFCHECK_EN
                        r_chk       <= 1'b0;
`endif
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_code_out  = r_code;
    assign o_err_flag  = r_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fns_encoder_seq.sv
// Randomized bench for fns_encoder_seq against a Zeckendorf lookup table built by enumerating all
// non-adjacent digit patterns and their weighted sums.
module tb_fns_encoder_seq;

    logic        clk;
    logic        rst_n;
    logic        i_in_valid;
    logic        o_in_ready;
    logic [8:0]  i_in_data;
    logic        o_out_valid;
    logic        i_out_ready;
    logic [11:0] o_code_out;
    logic        o_err_flag;
    logic [1:0]  o_dbg_state;
`ifdef FNS_ENC_SELFCHECK_EN
    logic        o_chk_err;
`endif

    int          n_checks;
    int          n_errors;
    int          wt [0:11];
    logic [11:0] zk [0:1023];
    int          maxv;

    fns_encoder_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_data   (i_in_data),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_code_out  (o_code_out),
        .o_err_flag  (o_err_flag),
        .o_dbg_state (o_dbg_state)
`ifdef FNS_ENC_SELFCHECK_EN
        ,.o_chk_err  (o_chk_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge; waits (bounded) until the encoder offers in_ready.
    task automatic wait_ready();
        int n;
        n = 0;
        while (!o_in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!o_in_ready) check("ready_timeout", 32'(o_in_ready), 32'd1);
    endtask

    task automatic send(input int v, input int stall);
        int          lat;
        int          exp_lat;
        logic [11:0] exp_code;
        logic        exp_err;
        exp_err  = (v > maxv);
        exp_code = exp_err ? 12'h000 : zk[v];
        exp_lat  = exp_err ? 1 : 13;
        @(negedge clk);
        wait_ready();
        i_in_valid = 1'b1;
        i_in_data  = 9'(v);
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        lat = 1;
        while (!o_out_valid && lat < 40) begin
            i_in_valid = 1'($urandom_range(0, 1));
            i_in_data  = 9'($urandom);
            @(posedge clk);
            #1;
            lat++;
        end
        i_in_valid = 1'b0;
        check("latency", 32'(lat), 32'(exp_lat));
        check("code", 32'(o_code_out), 32'(exp_code));
        check("err", 32'(o_err_flag), 32'(exp_err));
`ifdef FNS_ENC_SELFCHECK_EN
        check("chk_err", 32'(o_chk_err), 32'd0);
`endif
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            check("hold_code", 32'(o_code_out), 32'(exp_code));
            check("hold_valid", 32'(o_out_valid), 32'd1);
            check("hold_ready", 32'(o_in_ready), 32'd0);
        end
        i_out_ready = 1'b1;
        @(posedge clk);
        #1;
        i_out_ready = 1'b0;
        check("released", 32'(o_out_valid), 32'd0);
    endtask

    initial begin
        logic [11:0] cb;
        int          s;
        int          acc [0:1];
        int          nacc;
        int          cyc;

        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 12; i++) wt[i] = (i == 0) ? 1 : (i == 1) ? 2 : wt[i-1] + wt[i-2];
        maxv = 0;
        for (int c = 0; c < 4096; c++) begin
            cb = 12'(c);
            if ((cb & (cb >> 1)) == 12'h000) begin
                s = 0;
                for (int i = 0; i < 12; i++) if (cb[i]) s += wt[i];
                zk[s] = cb;
                if (s > maxv) maxv = s;
            end
        end

        rst_n       = 1'b0;
        i_in_valid  = 1'b0;
        i_in_data   = '0;
        i_out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(o_in_ready), 32'd0);
        check("rst_out_valid", 32'(o_out_valid), 32'd0);
        check("rst_code", 32'(o_code_out), 32'd0);
        check("rst_err", 32'(o_err_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("ready_after_rst", 32'(o_in_ready), 32'd1);

        send(0, 0);
        send(255, 0);
        check("dir_255", 32'(o_code_out), 32'h841);
        send(376, 0);
        check("dir_376", 32'(o_code_out), 32'hAAA);
        send(100, 0);
        check("dir_100", 32'(o_code_out), 32'h214);
        send(377, 2);
        send(400, 1);
        send(511, 0);
        send(255, 5);

        // Back-to-back throughput with out_ready held high.
        i_out_ready = 1'b1;
        i_in_data   = 9'd100;
        @(negedge clk);
        wait_ready();
        i_in_valid = 1'b1;
        nacc = 0;
        cyc  = 0;
        acc[0] = 0;
        acc[1] = 0;
        while (nacc < 2 && cyc < 100) begin
            if (o_in_ready && i_in_valid) begin
                acc[nacc] = cyc;
                nacc++;
            end
            @(negedge clk);
            cyc++;
        end
        i_in_valid = 1'b0;
        check("accepts", 32'(nacc), 32'd2);
        check("throughput", 32'(acc[1] - acc[0]), 32'd14);
        wait_ready();
        i_out_ready = 1'b0;

        // Reset in the middle of ENC (digit index 6).
        @(negedge clk);
        wait_ready();
        i_in_valid = 1'b1;
        i_in_data  = 9'd255;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_valid", 32'(o_out_valid), 32'd0);
        check("abort_code", 32'(o_code_out), 32'd0);
        check("abort_err", 32'(o_err_flag), 32'd0);
        check("abort_ready", 32'(o_in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        send(255, 0);
        check("post_abort_255", 32'(o_code_out), 32'h841);

        // Reset while an error word waits in DONE.
        @(negedge clk);
        wait_ready();
        i_in_valid = 1'b1;
        i_in_data  = 9'd450;
        @(posedge clk);
        #1;
        i_in_valid = 1'b0;
        check("err_path_valid", 32'(o_out_valid), 32'd1);
        check("err_path_err", 32'(o_err_flag), 32'd1);
        rst_n = 1'b0;
        #1;
        check("done_abort_valid", 32'(o_out_valid), 32'd0);
        check("done_abort_err", 32'(o_err_flag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int n = 0; n < 40; n++) send(int'($urandom_range(0, 511)), int'($urandom_range(0, 3)));
        for (int v = 0; v <= 376; v++) send(v, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
